active_trigger_bank: RTL and testbench
======================================

# active_trigger_bank

Parametrised successor to the single-byte trigger bridge: moves up to 64 trigger bits between user logic and the host across the 30-bit uc_out / 32-bit uc_in link, one 8-bit lane per transfer. Host-bound rising edges are captured per bit, held sticky until reported, and serviced by a round-robin lane scheduler with a fixed hold/gap cadence. Device-bound trigger commands are decoded by lane address into one-cycle pulses. Sits between the user application and the transfer controller.

## Interface
- NUM_LANES, 2 — number of 8-bit trigger lanes, 1..8
- HOLD_CYCLES, 4 — cycles uc_out[8] is held high per report, 1..15
- GAP_CYCLES, 1 — idle cycles forced between reports, 1..15
- uc_clk  in  1  sole clock, all logic on rising edge
- uc_reset  in  1  synchronous, active-high reset
- uc_in  in  32  host command word; [29:27] lane, [8] trigger command, [7:0] trigger byte
- uc_out  out  30  [29:27] lane, [26:9] 0, [8] trigger command, [7:0] trigger byte
- trigger_to_host  in  8*NUM_LANES  user trigger levels, lane n = bits [8n+7:8n]
- trigger_to_device  out  8*NUM_LANES  one-cycle device trigger pulses
- trig_overflow  out  NUM_LANES  sticky per-lane lost-edge flag (only with ACTIVE_TRIGGER_OVF_EN)

## Operation
- Edge capture: prev_q registers trigger_to_host each cycle; rise = trigger_to_host & ~prev_q. Rise bits OR into pending (8*NUM_LANES sticky). A level held high reports once; it must fall and rise again to re-report.
- Host FSM, states IDLE, HOLD, GAP:
  - IDLE: if any lane has a pending bit, round-robin pick starting at lane after last served (wrap at NUM_LANES-1 → 0). Snapshot that lane's pending byte into uc_out[7:0], lane index into uc_out[29:27], set uc_out[8], clear that lane's pending, go HOLD.
  - HOLD: keep uc_out stable for HOLD_CYCLES cycles total, then zero all of uc_out, go GAP.
  - GAP: GAP_CYCLES cycles with uc_out = 0, then IDLE.
- Same-edge clear and new rise on the same pending bit: set wins (the bit stays pending for next report).
- Device path: uc_in[8] registered; on its 0→1 transition, if uc_in[29:27] < NUM_LANES, trigger_to_device lane uc_in[29:27] = uc_in[7:0] for exactly one cycle, all other bits 0. Lane ≥ NUM_LANES: ignored. uc_in[8] held high produces one pulse only.
- Host and device paths are independent; both may act in the same cycle.

## Timing
- Reset: uc_out = 0, trigger_to_device = 0, trig_overflow = 0, pending = 0, prev_q = 0, FSM = IDLE, round-robin pointer = NUM_LANES-1 (lane 0 served first).
- Rise sampled at edge k → pending set after k → uc_out[8] high after edge k+1 (latency 2 cycles from input change) if FSM in IDLE.
- Report period = HOLD_CYCLES + GAP_CYCLES + 1 cycles (one IDLE decision cycle) back-to-back.
- Device latency: uc_in[8] rise at edge k → pulse visible after edge k+1, width 1 cycle.
- All outputs registered; no combinational input-to-output path.
- Reset mid-HOLD: uc_out drops to 0 on the reset edge; pending events are lost.

## Configuration
- ACTIVE_TRIGGER_OVF_EN defined: trig_overflow port exists; bit n sets when a rise occurs on a lane-n bit that is already pending and not being cleared that edge; cleared only by uc_reset.
- Undefined: port and logic absent; repeated rises merge silently into pending.

## Structure
- active_trigger_pkg: uc_out/uc_in field position constants (LANE_MSB 29, LANE_LSB 27, CMD_BIT 8, BYTE_MSB 7), FSM state encoding, max NUM_LANES constant 8.
- One sub-module: trig_rr_arbiter (NUM_LANES request vector + last-served pointer → grant index, valid).

## Test plan
- Reset, NUM_LANES=2: trigger_to_host=16'h0001 at edge k → uc_out = {3'd0,18'd0,1'b1,8'h01} after edge k+1 for 4 cycles, then 0 for 2 cycles minimum.
- Simultaneous 16'h8001 rise → lane 0 report (8'h01), then lane 1 report (uc_out[29:27]=1, 8'h80), reports separated by 1 gap + 1 idle cycle.
- Bit 0 held high 100 cycles → exactly one report; drop and re-raise → second report.
- Bit 2 rises during lane-0 HOLD after snapshot → separate lane-0 report 8'h04 follows; with ACTIVE_TRIGGER_OVF_EN, bit 2 toggled twice before service sets trig_overflow[0].
- uc_in lane=1, [8]=1, byte 8'hA5 held 10 cycles → trigger_to_device[15:8]=8'hA5 for one cycle only; lane=5 → no pulse.
- uc_reset asserted mid-HOLD → uc_out=0 next cycle, pending cleared, next report starts from lane 0.

Source files
------------

// File: rtl/active_trigger_bank_pkg.sv
// -----------------------------------------------------------------------------
// active_trigger_pkg
// Shared constants for the active trigger bank: uc_out / uc_in field positions,
// link widths, the lane-count ceiling and the host-report FSM encoding.
// Optional feature macro used by the bank: ACTIVE_TRIGGER_OVF_EN.
// -----------------------------------------------------------------------------
package active_trigger_pkg;

    localparam int UC_IN_W   = 32;
    localparam int UC_OUT_W  = 30;
    localparam int LANE_MSB  = 29;
    localparam int LANE_LSB  = 27;
    localparam int CMD_BIT   = 8;
    localparam int BYTE_MSB  = 7;
    localparam int MAX_LANES = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HOLD = 2'd1,
        ST_GAP  = 2'd2
    } host_state_e;

endpackage

// File: rtl/active_trigger_bank_if.sv
// -----------------------------------------------------------------------------
// active_trigger_bank_if
// Host link between the trigger bank and the transfer controller.
//   uc_in  [31:0] : host command word (controller -> bank)
//   uc_out [29:0] : trigger report word (bank -> controller)
// Modports: master = transfer controller side, slave = trigger bank side.
// -----------------------------------------------------------------------------
interface active_trigger_bank_if;
    import active_trigger_pkg::*;

    logic [UC_IN_W-1:0]  uc_in;
    logic [UC_OUT_W-1:0] uc_out;

    modport master (output uc_in, input  uc_out);
    modport slave  (input  uc_in, output uc_out);
endinterface

// File: rtl/active_trigger_bank_arb.sv
// -----------------------------------------------------------------------------
// trig_rr_arbiter
// Round-robin lane picker. Search starts at the lane after the last served one
// and wraps at NUM_LANES-1 -> 0.
//   req_i  [NUM_LANES-1:0] : lane has at least one pending bit
//   last_i [2:0]           : lane served by the previous report
//   gnt_o  [2:0]           : chosen lane (valid only with vld_o)
//   vld_o                  : some lane is requesting
// -----------------------------------------------------------------------------
module trig_rr_arbiter
    import active_trigger_pkg::*;
#(
    parameter int NUM_LANES = 2
) (
    input  logic [NUM_LANES-1:0] req_i,
    input  logic [2:0]           last_i,
    output logic [2:0]           gnt_o,
    output logic                 vld_o
);

    // Padded to the 8-lane ceiling so a 3-bit index always fits exactly.
    logic [MAX_LANES-1:0] req_ext;
    logic [3:0]           idx;

    assign req_ext = MAX_LANES'(req_i);

    always_comb begin
        gnt_o = '0;
        vld_o = 1'b0;
        idx   = '0;
        for (int i = 1; i <= NUM_LANES; i++) begin
            // last_i < NUM_LANES, so one conditional subtract performs the wrap.
            idx = {1'b0, last_i} + 4'(i);
            if (idx >= 4'(NUM_LANES)) idx = idx - 4'(NUM_LANES);
            if (!vld_o && req_ext[idx[2:0]]) begin
                gnt_o = idx[2:0];
                vld_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/active_trigger_bank.sv
// -----------------------------------------------------------------------------
// active_trigger_bank
// Moves up to 8*NUM_LANES trigger bits between user logic and the host link,
// one 8-bit lane per transfer.
//   uc_clk, uc_reset  : clock, synchronous active-high reset
//   bus (slave)       : uc_in command word in, uc_out report word out
//   trigger_to_host   : user trigger levels, lane n = bits [8n+7:8n]
//   trigger_to_device : one-cycle pulses decoded from host commands
//   trig_overflow     : sticky per-lane lost-edge flag, present only when
//                       ACTIVE_TRIGGER_OVF_EN is defined
// Host path: rising edges go sticky into pending, a round-robin scheduler
// reports one lane at a time with a HOLD_CYCLES / GAP_CYCLES cadence.
// Device path: a 0->1 on uc_in[8] fires one pulse on the addressed lane.
// -----------------------------------------------------------------------------
module active_trigger_bank
    import active_trigger_pkg::*;
#(
    parameter int NUM_LANES   = 2,
    parameter int HOLD_CYCLES = 4,
    parameter int GAP_CYCLES  = 1
) (
    input  logic                   uc_clk,
    input  logic                   uc_reset,
    active_trigger_bank_if.slave   bus,
    input  logic [8*NUM_LANES-1:0] trigger_to_host,
    output logic [8*NUM_LANES-1:0] trigger_to_device
`ifdef ACTIVE_TRIGGER_OVF_EN
    ,
    output logic [NUM_LANES-1:0]   trig_overflow
`endif
);

    localparam int TW = 8 * NUM_LANES;

    // ---------------- host path ----------------
    logic [TW-1:0]        prev_q, pend_q, pend_d, rise, clr_bits;
    logic [NUM_LANES-1:0] lane_req;
    logic [2:0]           gnt, last_q, last_d;
    logic                 gnt_vld;
    logic [3:0]           cnt_q, cnt_d;
    logic [UC_OUT_W-1:0]  out_q, out_d;
    host_state_e          state_q, state_d;

    logic [MAX_LANES-1:0][7:0] pend_ext, clr_ext;

    assign rise     = trigger_to_host & ~prev_q;
    assign pend_ext = (8*MAX_LANES)'(pend_q);
    assign clr_bits = TW'(clr_ext);
    // Set wins over the report's clear so a same-edge rise is kept for later.
    assign pend_d   = (pend_q & ~clr_bits) | rise;

    always_comb begin
        lane_req = '0;
        for (int l = 0; l < NUM_LANES; l++) lane_req[l] = |pend_q[8*l +: 8];
    end

    trig_rr_arbiter #(.NUM_LANES(NUM_LANES)) u_arb (
        .req_i  (lane_req),
        .last_i (last_q),
        .gnt_o  (gnt),
        .vld_o  (gnt_vld)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        last_d  = last_q;
        out_d   = out_q;
        clr_ext = '0;
        case (state_q)
            ST_IDLE: begin
                if (gnt_vld) begin
                    out_d                    = '0;
                    out_d[LANE_MSB:LANE_LSB] = gnt;
                    out_d[CMD_BIT]           = 1'b1;
                    out_d[BYTE_MSB:0]        = pend_ext[gnt];
                    clr_ext[gnt]             = 8'hFF;
                    last_d                   = gnt;
                    cnt_d                    = 4'(HOLD_CYCLES - 1);
                    state_d                  = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (cnt_q == 4'd0) begin
                    out_d   = '0;
                    cnt_d   = 4'(GAP_CYCLES - 1);
                    state_d = ST_GAP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_GAP: begin
                if (cnt_q == 4'd0) state_d = ST_IDLE;
                else               cnt_d   = cnt_q - 4'd1;
            end
            default: begin
                out_d   = '0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // ---------------- device path ----------------
    logic [2:0]                lane_q;
    logic [7:0]                byte_q;
    logic                      cmd_q, cmd_prev_q;
    logic [TW-1:0]             tdev_q, tdev_d;
    logic [MAX_LANES-1:0][7:0] dev_ext;
    logic                      unused_uc_in;

    assign unused_uc_in = ^{bus.uc_in[31:30], bus.uc_in[26:9]};

    always_comb begin
        dev_ext = '0;
        if (cmd_q && !cmd_prev_q && ({1'b0, lane_q} < 4'(NUM_LANES)))
            dev_ext[lane_q] = byte_q;
        tdev_d = TW'(dev_ext);
    end

`ifdef ACTIVE_TRIGGER_OVF_EN
    logic [NUM_LANES-1:0] ovf_q, ovf_d;
    logic [TW-1:0]        ovf_hit;

    // A rise on a bit still waiting to be reported means one edge was merged.
    assign ovf_hit = rise & pend_q & ~clr_bits;

    always_comb begin
        ovf_d = ovf_q;
        for (int l = 0; l < NUM_LANES; l++) ovf_d[l] = ovf_q[l] | (|ovf_hit[8*l +: 8]);
    end

    always_ff @(posedge uc_clk) begin
        if (uc_reset) ovf_q <= '0;
        else          ovf_q <= ovf_d;
    end

    assign trig_overflow = ovf_q;
`endif

    always_ff @(posedge uc_clk) begin
        if (uc_reset) begin
            prev_q     <= '0;
            pend_q     <= '0;
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            last_q     <= 3'(NUM_LANES - 1);
            out_q      <= '0;
            lane_q     <= '0;
            byte_q     <= '0;
            cmd_q      <= 1'b0;
            cmd_prev_q <= 1'b0;
            tdev_q     <= '0;
        end else begin
            prev_q     <= trigger_to_host;
            pend_q     <= pend_d;
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            last_q     <= last_d;
            out_q      <= out_d;
            lane_q     <= bus.uc_in[LANE_MSB:LANE_LSB];
            byte_q     <= bus.uc_in[BYTE_MSB:0];
            cmd_q      <= bus.uc_in[CMD_BIT];
            cmd_prev_q <= cmd_q;
            tdev_q     <= tdev_d;
        end
    end

    assign bus.uc_out        = out_q;
    assign trigger_to_device = tdev_q;

endmodule

// File: tb/tb_active_trigger_bank.sv
// -----------------------------------------------------------------------------
// tb_active_trigger_bank
// Directed stimulus for active_trigger_bank (NUM_LANES=2, HOLD=4, GAP=1).
// Stimulus pushes expected report words / device pulses with the cycle they
// must appear on; a negedge monitor pops and compares whenever the DUT shows a
// report or a pulse, and also checks hold length, gap length and idle zeros.
// -----------------------------------------------------------------------------
module tb_active_trigger_bank;

    localparam int H = 4;
    localparam int G = 1;

    typedef struct { logic [29:0] word; int due; } rep_t;
    typedef struct { logic [15:0] val;  int due; } dev_t;

    logic        uc_clk = 1'b0;
    logic        uc_reset = 1'b1;
    logic [15:0] tth = '0;
    logic [15:0] tdev;
`ifdef ACTIVE_TRIGGER_OVF_EN
    logic [1:0]  ovf;
`endif

    active_trigger_bank_if bus_if();

    active_trigger_bank #(.NUM_LANES(2), .HOLD_CYCLES(H), .GAP_CYCLES(G)) dut (
        .uc_clk            (uc_clk),
        .uc_reset          (uc_reset),
        .bus               (bus_if),
        .trigger_to_host   (tth),
        .trigger_to_device (tdev)
`ifdef ACTIVE_TRIGGER_OVF_EN
        ,
        .trig_overflow     (ovf)
`endif
    );

    always #5 uc_clk = ~uc_clk;

    int cyc = 0;
    always @(posedge uc_clk) cyc++;

    int   checks = 0;
    int   fails  = 0;
    rep_t exp_q[$];
    dev_t dev_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s got=%h exp=%h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge uc_clk);
        #1;
    endtask

    function automatic logic [29:0] rep(input logic [2:0] lane, input logic [7:0] b);
        return {lane, 18'd0, 1'b1, b};
    endfunction

    function automatic logic [31:0] cmd(input logic [2:0] lane, input logic [7:0] b);
        return {2'b00, lane, 18'd0, 1'b1, b};
    endfunction

    // ---------------- monitor ----------------
    bit          in_rep = 0;
    int          hold = 0;
    int          gap = 99;
    logic [29:0] held = '0;

    always @(negedge uc_clk) begin
        rep_t e;
        dev_t d;
        if (uc_reset) begin
            in_rep = 0;
            hold   = 0;
            gap    = 99;
        end else begin
            if (bus_if.uc_out[8] && !in_rep) begin
                checks++;
                if (exp_q.size() == 0) begin
                    fails++;
                    $display("FAIL unexpected_report got=%h cyc=%0d exp=none", bus_if.uc_out, cyc);
                end else begin
                    e = exp_q.pop_front();
                    if (bus_if.uc_out !== e.word || cyc != e.due) begin
                        fails++;
                        $display("FAIL report got=%h@%0d exp=%h@%0d", bus_if.uc_out, cyc, e.word, e.due);
                    end
                end
                checks++;
                if (gap < G + 1) begin
                    fails++;
                    $display("FAIL gap_len got=%0d exp>=%0d", gap, G + 1);
                end
                in_rep = 1;
                hold   = 1;
                held   = bus_if.uc_out;
            end else if (in_rep && bus_if.uc_out[8]) begin
                hold++;
                checks++;
                if (bus_if.uc_out !== held) begin
                    fails++;
                    $display("FAIL report_stable got=%h exp=%h", bus_if.uc_out, held);
                end
            end else if (in_rep) begin
                in_rep = 0;
                checks++;
                if (hold != H) begin
                    fails++;
                    $display("FAIL hold_len got=%0d exp=%0d", hold, H);
                end
                checks++;
                if (bus_if.uc_out !== 30'd0) begin
                    fails++;
                    $display("FAIL report_clear got=%h exp=0", bus_if.uc_out);
                end
                gap = 1;
            end else begin
                checks++;
                if (bus_if.uc_out !== 30'd0) begin
                    fails++;
                    $display("FAIL idle_zero got=%h exp=0", bus_if.uc_out);
                end
                if (gap < 99) gap++;
            end

            if (tdev !== 16'h0000) begin
                checks++;
                if (dev_q.size() == 0) begin
                    fails++;
                    $display("FAIL unexpected_pulse got=%h cyc=%0d exp=none", tdev, cyc);
                end else begin
                    d = dev_q.pop_front();
                    if (tdev !== d.val || cyc != d.due) begin
                        fails++;
                        $display("FAIL dev_pulse got=%h@%0d exp=%h@%0d", tdev, cyc, d.val, d.due);
                    end
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        int c;
        bus_if.uc_in = '0;
        tick(3);
        chk("reset_uc_out", 32'(bus_if.uc_out), 32'd0);
        chk("reset_tdev", 32'(tdev), 32'd0);
`ifdef ACTIVE_TRIGGER_OVF_EN
        chk("reset_ovf", 32'(ovf), 32'd0);
`endif
        uc_reset = 1'b0;
        tick(2);

        // single rise, 2-cycle latency; then held high -> no repeat report
        tth = 16'h0001; c = cyc;
        exp_q.push_back('{rep(3'd0, 8'h01), c + 2});
        tick(100);
        tth = 16'h0000;
        tick(2);
        tth = 16'h0001; c = cyc;
        exp_q.push_back('{rep(3'd0, 8'h01), c + 2});
        tick(20);

        // reset, then two lanes at once: lane 0 first, lane 1 one period later
        tth = 16'h0000;
        tick(2);
        uc_reset = 1'b1;
        tick(2);
        uc_reset = 1'b0;
        tick(2);
        tth = 16'h8001; c = cyc;
        exp_q.push_back('{rep(3'd0, 8'h01), c + 2});
        exp_q.push_back('{rep(3'd1, 8'h80), c + 2 + H + G + 1});
        tick(20);

        // bit 2 rises (twice) during the lane-0 hold -> follow-up report 8'h04
        tth = 16'h0000;
        tick(2);
        tth = 16'h0001; c = cyc;
        exp_q.push_back('{rep(3'd0, 8'h01), c + 2});
        exp_q.push_back('{rep(3'd0, 8'h04), c + 2 + H + G + 1});
        tick(3);
        tth = 16'h0005;
        tick(1);
        tth = 16'h0001;
        tick(1);
        tth = 16'h0005;
        tick(20);
`ifdef ACTIVE_TRIGGER_OVF_EN
        chk("ovf_lane0", 32'(ovf), 32'h1);
`endif

        // device path: held command -> one pulse; out-of-range lane ignored
        bus_if.uc_in = cmd(3'd1, 8'hA5); c = cyc;
        dev_q.push_back('{16'hA500, c + 2});
        tick(10);
        bus_if.uc_in = '0;
        tick(2);
        bus_if.uc_in = cmd(3'd5, 8'hFF);
        tick(3);
        bus_if.uc_in = '0;
        tick(2);
        bus_if.uc_in = cmd(3'd0, 8'h3C); c = cyc;
        dev_q.push_back('{16'h003C, c + 2});
        tick(2);
        bus_if.uc_in = '0;
        tick(3);

        // reset mid-hold: output clears, pending lost, lane 0 served first after
        tth = 16'h0000;
        tick(2);
        tth = 16'h0201; c = cyc;
        exp_q.push_back('{rep(3'd1, 8'h02), c + 2});
        tick(3);
        uc_reset = 1'b1;
        tth = 16'h0000;
        tick(1);
        chk("reset_midhold_uc_out", 32'(bus_if.uc_out), 32'd0);
        tick(1);
        uc_reset = 1'b0;
`ifdef ACTIVE_TRIGGER_OVF_EN
        chk("ovf_after_reset", 32'(ovf), 32'd0);
`endif
        tick(10);
        tth = 16'h0201; c = cyc;
        exp_q.push_back('{rep(3'd0, 8'h01), c + 2});
        exp_q.push_back('{rep(3'd1, 8'h02), c + 2 + H + G + 1});
        tick(20);

        chk("reports_left", 32'(exp_q.size()), 32'd0);
        chk("pulses_left", 32'(dev_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
